array_3_queue: RTL and testbench

Ready/valid FIFO controller that owns the single-port 256x47 `array_3_ext` macro and turns it into a 258-entry queue. It sits directly upstream of the array: it drives the macro's address, enable, write-mode and write-data pins, and consumes its one-cycle-latency read data. Read/write contention on the single port is arbitrated internally. A 2-entry output buffer hides read latency and decouples `deq_ready` from the RAM port.

---
 rtl/array_3_pkg.sv | 8 +
 rtl/array_3_queue_obuf.sv | 60 ++++++
 rtl/array_3_queue.sv | 94 +++++++++
 tb/tb_array_3_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_3_pkg.sv
// Shared sizes and payload type for the array_3 queue and the 256x47 macro it owns.
package array_3_pkg;
    localparam int ARRAY_3_DEPTH  = 256;
    localparam int ARRAY_3_WIDTH  = 47;
    localparam int ARRAY_3_ADDR_W = 8;

    typedef logic [ARRAY_3_WIDTH-1:0] array_3_data_t;
endpackage

// File: rtl/array_3_queue_obuf.sv
// Two-entry output FIFO that catches the macro's read data and presents the queue head.
module array_3_queue_obuf
    import array_3_pkg::*;
#(
    parameter int WIDTH = ARRAY_3_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       cnt,
    output logic             valid,
    output logic [WIDTH-1:0] head
);
    logic [1:0]       cnt_reg;
    logic [1:0]       cnt_next;
    logic             head_idx_reg;
    logic             valid_reg;
    logic             push_idx;
    logic [WIDTH-1:0] slot_reg [2];

    // With one entry held the free slot is the other one; when full, a push
    // is only legal alongside a pop, so it reuses the slot being vacated.
    assign push_idx = head_idx_reg ^ (cnt_reg == 2'd1);
    assign cnt_next = 2'(cnt_reg + {1'b0, push} - {1'b0, pop});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg      <= 2'd0;
            head_idx_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else if (clear) begin
            cnt_reg      <= 2'd0;
            head_idx_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            valid_reg <= (cnt_next != 2'd0);
            if (pop) begin
                head_idx_reg <= ~head_idx_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clock) begin
                if (push && !clear && (push_idx == 1'(gi))) begin
                    slot_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign cnt   = cnt_reg;
    assign valid = valid_reg;
    assign head  = slot_reg[head_idx_reg];
endmodule

// File: rtl/array_3_queue.sv
// 258-entry ready/valid queue built on the single-port array_3_ext macro;
// reads win the port, and a 2-entry output buffer absorbs the read latency.
module array_3_queue
    import array_3_pkg::*;
#(
    parameter int DEPTH  = ARRAY_3_DEPTH,
    parameter int WIDTH  = ARRAY_3_WIDTH,
    parameter int ADDR_W = ARRAY_3_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_data,
    output logic [8:0]        count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);
    localparam logic [ADDR_W:0] RAM_FULL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   ram_cnt_reg;
    logic              inflight_reg;
    logic [1:0]        buf_cnt;
    logic [2:0]        credits_used;
    logic              rd_go;
    logic              wr_go;
    logic              pop;

    // A read is only issued when the buffer can take it even if nobody pops,
    // so deq_ready never reaches the RAM port.
    assign credits_used = {1'b0, buf_cnt} + {2'b00, inflight_reg};
    assign rd_go        = (ram_cnt_reg != '0) && (credits_used < 3'd2) && !flush;
    assign enq_ready    = reset_n && (ram_cnt_reg != RAM_FULL) && !rd_go && !flush;
    assign wr_go        = enq_valid && enq_ready;
    assign pop          = deq_valid && deq_ready;

    assign mem_en    = rd_go || wr_go;
    assign mem_wmode = wr_go;
    assign mem_addr  = rd_go ? rd_ptr_reg : wr_ptr_reg;
    assign mem_wdata = enq_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ram_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= rd_go;
            if (rd_go) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (wr_go) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case ({rd_go, wr_go})
                2'b10:   ram_cnt_reg <= ram_cnt_reg - 1'b1;
                2'b01:   ram_cnt_reg <= ram_cnt_reg + 1'b1;
                default: ram_cnt_reg <= ram_cnt_reg;
            endcase
        end
    end

    array_3_queue_obuf #(
        .WIDTH(WIDTH)
    ) u_obuf (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (flush),
        .push     (inflight_reg),
        .push_data(mem_rdata),
        .pop      (pop),
        .cnt      (buf_cnt),
        .valid    (deq_valid),
        .head     (deq_data)
    );

    // An entry in flight is in neither term, hence the one-cycle dip.
    assign count = 9'(ram_cnt_reg) + 9'(buf_cnt);
endmodule

// File: tb/tb_array_3_queue.sv
// Scoreboard bench for array_3_queue with a behavioural model of the array_3_ext macro.
module tb_array_3_queue;
    import array_3_pkg::*;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    array_3_data_t enq_data = '0;
    logic          deq_valid;
    logic          deq_ready = 1'b0;
    array_3_data_t deq_data;
    logic [8:0]    count;
    logic [7:0]    mem_addr;
    logic          mem_en;
    logic          mem_wmode;
    array_3_data_t mem_wdata;
    array_3_data_t mem_rdata;

    int n_cmp = 0;
    int n_fail = 0;
    int n_popped = 0;
    array_3_data_t exp_q[$];
    logic [7:0] wr_model = '0;
    array_3_data_t ram [256];

    array_3_queue dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_data (enq_data),
        .deq_valid(deq_valid),
        .deq_ready(deq_ready),
        .deq_data (deq_data),
        .count    (count),
        .mem_addr (mem_addr),
        .mem_en   (mem_en),
        .mem_wmode(mem_wmode),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Single-port macro: one-cycle read latency, contents survive reset.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) ram[mem_addr] <= mem_wdata;
            else           mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enq(input array_3_data_t d);
        enq_valid = 1'b1;
        enq_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (enq_ready) begin
                tick();
                enq_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_fail++;
        $display("FAIL enq_timeout: enq_ready got 0 for 50 cycles required 1 (data %h)", d);
        enq_valid = 1'b0;
    endtask

    always @(negedge reset_n) begin
        exp_q.delete();
        wr_model = '0;
    end

    // Monitor: occupancy, port legality, then this cycle's handshakes.
    always @(negedge clock) begin
        int d;
        if (reset_n) begin
            d = exp_q.size() - int'(count);
            n_cmp++;
            if (d != 0 && d != 1) begin
                n_fail++;
                $display("FAIL count_vs_model: count got %0d required %0d (or one less while a read is in flight)",
                         count, exp_q.size());
            end
            if (flush) begin
                check("flush_port", {62'd0, enq_ready, mem_en}, 64'd0);
                exp_q.delete();
                wr_model = '0;
            end else begin
                if (mem_en && !mem_wmode) check("enq_ready_in_read", 64'(enq_ready), 64'd0);
                if (enq_valid && enq_ready) begin
                    check("wr_port", {7'd0, mem_en, mem_wmode, mem_addr, mem_wdata},
                          {7'd0, 1'b1, 1'b1, wr_model, enq_data});
                    exp_q.push_back(enq_data);
                    wr_model++;
                end
                if (deq_valid && deq_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL deq_unexpected: got %h required no output", deq_data);
                    end else begin
                        check("deq_data", 64'(deq_data), 64'(exp_q.pop_front()));
                    end
                    n_popped++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time got limit required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int found;

        // Reset state
        #3;
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd0);
        #20 reset_n = 1'b1;
        tick();
        @(negedge clock);
        check("post_rst_enq_ready", 64'(enq_ready), 64'd1);
        tick();

        // Single enqueue: latency and count dip
        enq(47'h1234);
        @(negedge clock);
        check("lat_c1_count", 64'(count), 64'd1);
        check("lat_c1_valid", 64'(deq_valid), 64'd0);
        tick();
        @(negedge clock);
        check("lat_c2_count", 64'(count), 64'd0);
        check("lat_c2_valid", 64'(deq_valid), 64'd0);
        tick();
        @(negedge clock);
        check("lat_c3_count", 64'(count), 64'd1);
        check("lat_c3_valid", 64'(deq_valid), 64'd1);
        check("lat_c3_data", 64'(deq_data), 64'h1234);
        tick();
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;

        // Fill to 258 with no dequeue, then drain
        for (int i = 0; i < 258; i++) enq(47'(i));
        repeat (6) tick();
        @(negedge clock);
        check("full_count", 64'(count), 64'd258);
        check("full_enq_ready", 64'(enq_ready), 64'd0);
        check("full_deq_valid", 64'(deq_valid), 64'd1);
        check("full_head", 64'(deq_data), 64'd0);
        base = n_popped;
        tick();
        deq_ready = 1'b1;
        for (int k = 0; k < 1000 && n_popped < base + 258; k++) tick();
        deq_ready = 1'b0;
        check("drain_popped", 64'(n_popped - base), 64'd258);
        tick();
        @(negedge clock);
        check("drain_count", 64'(count), 64'd0);
        check("drain_deq_valid", 64'(deq_valid), 64'd0);
        tick();

        // Random interleave: 300 through the queue, pointers wrap
        base = n_popped;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [63:0] r;
                    r = {$urandom, $urandom};
                    repeat ($urandom_range(0, 2)) tick();
                    enq(r[46:0]);
                end
            end
            begin
                for (int k = 0; k < 6000 && n_popped < base + 300; k++) begin
                    deq_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                deq_ready = 1'b0;
            end
        join
        check("wrap_popped", 64'(n_popped - base), 64'd300);
        tick();

        // Flush the cycle after a read issue
        for (int i = 0; i < 5; i++) enq(47'(100 + i));
        repeat (5) tick();
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (mem_en && !mem_wmode) begin
                found = 1;
                break;
            end
        end
        check("flush_read_seen", 64'(found), 64'd1);
        tick();
        flush = 1'b1;
        @(negedge clock);
        tick();
        flush = 1'b0;
        @(negedge clock);
        check("flush_deq_valid", 64'(deq_valid), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        tick();
        @(negedge clock);
        check("flush_late_valid", 64'(deq_valid), 64'd0);
        check("flush_late_count", 64'(count), 64'd0);
        tick();

        // Asynchronous reset mid-drain
        for (int i = 0; i < 10; i++) enq(47'(200 + i));
        deq_ready = 1'b1;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        check("amid_rst_valid", 64'(deq_valid), 64'd0);
        check("amid_rst_count", 64'(count), 64'd0);
        check("amid_rst_mem_en", 64'(mem_en), 64'd0);
        check("amid_rst_enq_ready", 64'(enq_ready), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        tick();
        enq(47'h7);
        @(negedge clock);
        check("rst_lat_c1_valid", 64'(deq_valid), 64'd0);
        tick();
        @(negedge clock);
        check("rst_lat_c2_valid", 64'(deq_valid), 64'd0);
        tick();
        @(negedge clock);
        check("rst_lat_c3_valid", 64'(deq_valid), 64'd1);
        check("rst_lat_c3_data", 64'(deq_data), 64'h7);
        tick();
        deq_ready = 1'b0;
        repeat (3) tick();
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
